bcp_implication_queue: RTL and testbench

BCP_IMPLICATION_QUEUE -- requirements
Module: bcp_implication_queue

---
 rtl/bcp_implication_queue.sv | 174 +++++++++++++++++
 tb/tb_bcp_implication_queue.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/bcp_implication_queue.sv
// bcp_implication_queue: FIFO of implied literals produced by the BCP unit-check
// stage. Decodes the one-hot unit slot into {var, val}, queues it, and presents
// the head to the consumer with a valid/ready handshake.
// Optional build macro: BCP_DEDUP_EN enables duplicate suppression and conflict
// detection (same var implied both ways) plus the CONFLICT state.
module bcp_implication_queue #(
    parameter int VAR_W = 6,
    parameter int DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    input  logic [3:0]                   unit_clause,
    input  logic [4*VAR_W-1:0]           clause_vars,
    input  logic [3:0]                   clause_pol,
    input  logic                         imp_ready,
    input  logic                         clear,
    output logic                         imp_valid,
    output logic [VAR_W-1:0]             imp_var,
    output logic                         imp_val,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         conflict,
    output logic [VAR_W-1:0]             conflict_var,
    output logic                         overflow,
    output logic                         multi_err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    typedef enum logic [1:0] {IDLE, ACTIVE, CONFLICT} state_t;

    state_t             state;
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic [VAR_W-1:0]   mem_var [DEPTH];
    logic               mem_val [DEPTH];

    logic               one_hot;
    logic               multi;
    logic [VAR_W-1:0]   req_var;
    logic               req_val;
    logic               head_present;
    logic               pop;
    logic               any_dup;
    logic               any_opp;
    logic               push_req;
    logic               full;
    logic               accept;
    logic               drop;
    logic [CNT_W-1:0]   count_next;

    // Decode the unit slot into the implied literal and classify the request
    always_comb begin
        one_hot = in_valid && (unit_clause inside {4'b0001, 4'b0010, 4'b0100, 4'b1000});
        multi   = in_valid && ($countones(unit_clause) > 1);
        req_var = clause_vars[0 +: VAR_W];
        req_val = clause_pol[0];
        case (unit_clause)
            4'b0010: begin req_var = clause_vars[VAR_W   +: VAR_W]; req_val = clause_pol[1]; end
            4'b0100: begin req_var = clause_vars[2*VAR_W +: VAR_W]; req_val = clause_pol[2]; end
            4'b1000: begin req_var = clause_vars[3*VAR_W +: VAR_W]; req_val = clause_pol[3]; end
            default: ;
        endcase
    end

    // Head is hidden while in CONFLICT so the consumer never sees stale entries
    assign head_present = (state != CONFLICT) && (count != '0);
    assign imp_valid    = head_present;
    assign imp_var      = head_present ? mem_var[rd_ptr] : '0;
    assign imp_val      = head_present ? mem_val[rd_ptr] : 1'b0;
    assign pop          = head_present && imp_ready;

`ifdef BCP_DEDUP_EN
    logic [DEPTH-1:0] dup_hit;
    logic [DEPTH-1:0] opp_hit;

    // Compare the request against every live entry, including one being popped
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
            logic [PTR_W-1:0] offset;
            logic             live;
            assign offset      = PTR_W'(gi) - rd_ptr;
            assign live        = CNT_W'(offset) < count;
            assign dup_hit[gi] = live && (mem_var[gi] == req_var) && (mem_val[gi] == req_val);
            assign opp_hit[gi] = live && (mem_var[gi] == req_var) && (mem_val[gi] != req_val);
        end
    endgenerate

    assign any_dup = |dup_hit;
    assign any_opp = |opp_hit;
`else
    assign any_dup = 1'b0;
    assign any_opp = 1'b0;
`endif

    // Push/pop arbitration; a full queue only accepts when the head leaves
    always_comb begin
        push_req = one_hot && (state != CONFLICT) && !any_dup && !any_opp;
        full     = (count == CNT_W'(DEPTH));
        accept   = push_req && (!full || pop);
        drop     = push_req && full && !pop;
        case ({accept, pop})
            2'b10:   count_next = count + 1'b1;
            2'b01:   count_next = count - 1'b1;
            default: count_next = count;
        endcase
    end

    // Entry storage; stale contents are harmless because pointers gate validity
    always_ff @(posedge clk) begin
        if (accept && !clear) begin
            mem_var[wr_ptr] <= req_var;
            mem_val[wr_ptr] <= req_val;
        end
    end

    // Control state: pointers, occupancy, flags and the queue state machine
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            multi_err <= 1'b0;
            state     <= IDLE;
        end else begin
            multi_err <= multi;
            if (clear) begin
                rd_ptr   <= '0;
                wr_ptr   <= '0;
                count    <= '0;
                overflow <= 1'b0;
                state    <= IDLE;
            end
`ifdef BCP_DEDUP_EN
            else if (one_hot && (state != CONFLICT) && any_opp) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
                state  <= CONFLICT;
            end
`endif
            else begin
                if (pop)    rd_ptr   <= rd_ptr + 1'b1;
                if (accept) wr_ptr   <= wr_ptr + 1'b1;
                if (drop)   overflow <= 1'b1;
                count <= count_next;
                if (state != CONFLICT)
                    state <= (count_next == '0) ? IDLE : ACTIVE;
            end
        end
    end

`ifdef BCP_DEDUP_EN
    // Sticky conflict flag and the variable that was implied both ways
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            conflict     <= 1'b0;
            conflict_var <= '0;
        end else if (clear) begin
            conflict     <= 1'b0;
            conflict_var <= '0;
        end else if (one_hot && (state != CONFLICT) && any_opp) begin
            conflict     <= 1'b1;
            conflict_var <= req_var;
        end
    end
`else
    assign conflict     = 1'b0;
    assign conflict_var = '0;
`endif

endmodule

// File: tb/tb_bcp_implication_queue.sv
// Randomized + directed bench for bcp_implication_queue against a queue-based
// reference model. Build with BCP_DEDUP_EN defined to exercise deduplication.
module tb_bcp_implication_queue;

    localparam int VAR_W = 6;
    localparam int DEPTH = 8;
    localparam int CNT_W = $clog2(DEPTH+1);

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 in_valid = 1'b0;
    logic [3:0]           unit_clause = '0;
    logic [4*VAR_W-1:0]   clause_vars = '0;
    logic [3:0]           clause_pol = '0;
    logic                 imp_ready = 1'b0;
    logic                 clear = 1'b0;
    logic                 imp_valid;
    logic [VAR_W-1:0]     imp_var;
    logic                 imp_val;
    logic [CNT_W-1:0]     count;
    logic                 conflict;
    logic [VAR_W-1:0]     conflict_var;
    logic                 overflow;
    logic                 multi_err;

    bcp_implication_queue #(.VAR_W(VAR_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .unit_clause(unit_clause),
        .clause_vars(clause_vars), .clause_pol(clause_pol), .imp_ready(imp_ready),
        .clear(clear), .imp_valid(imp_valid), .imp_var(imp_var), .imp_val(imp_val),
        .count(count), .conflict(conflict), .conflict_var(conflict_var),
        .overflow(overflow), .multi_err(multi_err)
    );

    always #5 clk = ~clk;

    typedef struct {int v; int b;} ent_t;
    ent_t m_q[$];
    int   m_conflict = 0;
    int   m_cvar = 0;
    int   m_overflow = 0;
    int   m_multi = 0;
    int   total = 0;
    int   bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_conflict = 0;
        m_cvar = 0;
        m_overflow = 0;
        m_multi = 0;
    endtask

    // Reference behaviour for one clock edge, from the pre-edge state and inputs
    task automatic model_update();
        int ones, slot, v, b, dup, opp, pop;
        ones = $countones(unit_clause);
        pop = (!m_conflict && m_q.size() > 0 && imp_ready) ? 1 : 0;
        m_multi = (in_valid && ones > 1) ? 1 : 0;
        if (clear) begin
            m_q.delete();
            m_conflict = 0;
            m_cvar = 0;
            m_overflow = 0;
            return;
        end
        if (in_valid && ones == 1 && !m_conflict) begin
            slot = 0;
            for (int s = 0; s < 4; s++) if (unit_clause[s]) slot = s;
            v = int'(clause_vars[slot*VAR_W +: VAR_W]);
            b = int'(clause_pol[slot]);
            dup = 0;
            opp = 0;
`ifdef BCP_DEDUP_EN
            foreach (m_q[k]) if (m_q[k].v == v) begin
                if (m_q[k].b == b) dup = 1; else opp = 1;
            end
`endif
            if (opp) begin
                m_conflict = 1;
                m_cvar = v;
                m_q.delete();
                return;
            end
            if (pop) void'(m_q.pop_front());
            if (!dup) begin
                if (m_q.size() == DEPTH) m_overflow = 1;
                else m_q.push_back('{v, b});
            end
        end else if (pop) begin
            void'(m_q.pop_front());
        end
    endtask

    task automatic check_all(input string tag);
        int ev, evar, eval;
        ev   = (!m_conflict && m_q.size() > 0) ? 1 : 0;
        evar = ev ? m_q[0].v : 0;
        eval = ev ? m_q[0].b : 0;
        check({tag, ".imp_valid"}, 32'(imp_valid), ev);
        check({tag, ".imp_var"}, 32'(imp_var), evar);
        check({tag, ".imp_val"}, 32'(imp_val), eval);
        check({tag, ".count"}, 32'(count), m_q.size());
        check({tag, ".conflict"}, 32'(conflict), m_conflict);
        check({tag, ".conflict_var"}, 32'(conflict_var), m_cvar);
        check({tag, ".overflow"}, 32'(overflow), m_overflow);
        check({tag, ".multi_err"}, 32'(multi_err), m_multi);
    endtask

    // One transaction: inputs already set after a negedge; model at posedge; check at negedge
    task automatic step(input string tag);
        @(posedge clk);
        model_update();
        @(negedge clk);
        $display("%s: iv=%0b uc=%b rdy=%0b clr=%0b -> valid=%0b var=%0d val=%0b cnt=%0d cf=%0b ov=%0b me=%0b",
                 tag, in_valid, unit_clause, imp_ready, clear, imp_valid, imp_var, imp_val,
                 count, conflict, overflow, multi_err);
        check_all(tag);
    endtask

    task automatic push1(input string tag, input int v, input int b, input logic rdy);
        int slot;
        slot = $urandom_range(0, 3);
        in_valid = 1'b1;
        unit_clause = 4'(1 << slot);
        for (int s = 0; s < 4; s++) begin
            clause_vars[s*VAR_W +: VAR_W] = VAR_W'($urandom_range(0, 63));
            clause_pol[s] = 1'($urandom_range(0, 1));
        end
        clause_vars[slot*VAR_W +: VAR_W] = VAR_W'(v);
        clause_pol[slot] = 1'(b);
        imp_ready = rdy;
        clear = 1'b0;
        step(tag);
    endtask

    task automatic idle1(input string tag, input logic rdy, input logic clr);
        in_valid = 1'b0;
        unit_clause = '0;
        imp_ready = rdy;
        clear = clr;
        step(tag);
        clear = 1'b0;
    endtask

    initial begin
        // Reset state
        @(negedge clk);
        check_all("reset");
        rst = 1'b0;
        idle1("post_reset", 1'b0, 1'b0);

        // Single push into empty queue: latency one
        push1("req034", 5, 1, 1'b0);
        idle1("drain", 1'b1, 1'b0);

        // Same literal twice
        push1("req035a", 3, 0, 1'b0);
        push1("req035b", 3, 0, 1'b0);
`ifdef BCP_DEDUP_EN
        check("req035.count", 32'(count), 1);
`else
        check("req035.count", 32'(count), 2);
`endif
        idle1("clr0", 1'b0, 1'b1);

        // Opposite polarity of a queued variable
        push1("req036a", 7, 1, 1'b0);
        push1("req036b", 7, 0, 1'b0);
        push1("req036c", 9, 1, 1'b1);
        idle1("req036d", 1'b1, 1'b0);
        idle1("req036clr", 1'b0, 1'b1);

        // Overflow without pop, then full with simultaneous pop
        for (int i = 0; i < DEPTH; i++) push1("fill", 10 + i, i % 2, 1'b0);
        push1("req037ovf", 40, 1, 1'b0);
        idle1("clr1", 1'b0, 1'b1);
        for (int i = 0; i < DEPTH; i++) push1("fill", 20 + i, 1, 1'b0);
        push1("req037pop", 41, 0, 1'b1);
        idle1("clr2", 1'b0, 1'b1);

        // Multiple unit bits: dropped, one-cycle pulse
        push1("pre038", 2, 1, 1'b0);
        in_valid = 1'b1;
        unit_clause = 4'b0101;
        step("req038");
        idle1("req038b", 1'b0, 1'b0);
        idle1("clr3", 1'b0, 1'b1);

        // Asynchronous reset with four entries queued
        for (int i = 0; i < 4; i++) push1("fill4", 30 + i, 0, 1'b0);
        in_valid = 1'b0;
        unit_clause = '0;
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_all("req039async");
        @(negedge clk);
        rst = 1'b0;
        push1("req039push", 12, 1, 1'b0);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            int r;
            in_valid = ($urandom_range(0, 9) < 8);
            r = $urandom_range(0, 9);
            if (r == 0) unit_clause = '0;
            else if (r == 1) begin
                unit_clause = 4'($urandom_range(0, 15));
                if ($countones(unit_clause) < 2) unit_clause = 4'b1010;
            end else unit_clause = 4'(1 << $urandom_range(0, 3));
            for (int s = 0; s < 4; s++) begin
                clause_vars[s*VAR_W +: VAR_W] = VAR_W'($urandom_range(0, 11));
                clause_pol[s] = 1'($urandom_range(0, 1));
            end
            if ((i / 100) % 2 == 1) imp_ready = ($urandom_range(0, 9) < 2);
            else imp_ready = ($urandom_range(0, 9) < 7);
            clear = m_conflict ? ($urandom_range(0, 9) < 3) : ($urandom_range(0, 99) < 3);
            step("rand");
        end
        clear = 1'b0;
        in_valid = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
